free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter O_COUNT, default 128: number of physical registers; tag 0 is reserved for x0 and is never allocated.
REQ-002 SHALL have localparam TW = $clog2(O_COUNT): physical tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  pipeline flush; rebuilds the full free list.
REQ-006 SHALL have port alloc_valid  output  1  a free tag is available on alloc_tag.
REQ-007 SHALL have port alloc_ready  input  1  rename stage consumes alloc_tag this cycle.
REQ-008 SHALL have port alloc_tag  output  TW  next free physical tag.
REQ-009 SHALL have port free_valid  input  1  commit returns the tag on free_tag.
REQ-010 SHALL have port free_tag  input  TW  physical tag being released.
REQ-011 SHALL have port init_done  output  1  list is initialised and operational.
REQ-012 SHALL have port count  output  TW+1  number of tags currently free.

Function
REQ-013 SHALL implement a circular FIFO of O_COUNT-1 entries with head and tail pointers wrapping at O_COUNT-2 -> 0.
REQ-014 SHALL implement the FSM states INIT and RUN.
REQ-015 SHALL, in INIT, write tag k+1 at index k, one entry per cycle, for k = 0..O_COUNT-2, incrementing count each cycle.
REQ-016 SHALL take exactly O_COUNT-1 cycles in INIT and then enter RUN with count = O_COUNT-1.
REQ-017 SHALL drive alloc_valid = (state==RUN) && (count!=0), with alloc_tag = fifo[head] combinationally.
REQ-018 SHALL pop on alloc_valid && alloc_ready: head advances, count decrements.
REQ-019 SHALL push on free_valid && free_tag!=0 in RUN: fifo[tail] = free_tag, tail advances, count increments.
REQ-020 SHALL ignore free_tag == 0 in all states.
REQ-021 SHALL, on a simultaneous pop and push, leave count unchanged and move both pointers.
REQ-022 SHALL NOT bypass free_tag to alloc_tag when empty; a tag freed in cycle N is allocatable in cycle N+1 at the earliest.
REQ-023 SHALL treat a push with count == O_COUNT-1 and no pop as illegal: the push is dropped and count saturates.
REQ-024 SHALL ignore free_valid and alloc_ready during INIT.
REQ-025 SHALL, on flush (any state), enter INIT next cycle with head = tail = count = 0; flush has priority over pop and push that cycle.
REQ-026 SHALL drive init_done = (state==RUN).

Reset
REQ-027 SHALL, while reset is low, asynchronously force state = INIT, head = tail = count = 0, alloc_valid = 0 and init_done = 0.
REQ-028 SHALL NOT reset the FIFO storage; INIT rewrites it.
REQ-029 SHALL, on reset assertion mid-INIT or mid-RUN, abort and restart INIT after release.

Configuration
REQ-030 SHALL, with FREE_LIST_DOUBLE_FREE_CHECK_EN defined, keep an O_COUNT-bit in_list vector: set on push and during INIT, cleared on pop, bit 0 always 0.
REQ-031 SHALL, with FREE_LIST_DOUBLE_FREE_CHECK_EN defined, drop a push of a tag whose in_list bit is set and raise output double_free_err (1 bit), which is sticky until reset or flush.
REQ-032 SHALL, without FREE_LIST_DOUBLE_FREE_CHECK_EN, provide neither in_list nor the double_free_err port, and push freed tags unchecked.

Structure
REQ-033 SHALL take the physical-tag typedef (phys_tag_t, width $clog2(O_COUNT)) and O_COUNT from the shared riscv_isa package, also used by register_rename.
REQ-034 SHALL have no sub-module; FIFO, pointers and FSM are flat in free_list.

Verification (O_COUNT=8)
REQ-035 SHALL verify reset release: init_done rises after exactly 7 cycles, count=7, alloc_tag=1.
REQ-036 SHALL verify alloc_ready held high for 8 cycles: tags 1,2,...,7 are issued, then alloc_valid=0 and count=0.
REQ-037 SHALL verify that, when empty, free tag 5 in cycle N gives alloc_valid=0 in N and alloc_valid=1, alloc_tag=5 in N+1.
REQ-038 SHALL verify that simultaneous alloc and free of tag 3 at count=4 keeps count=4 and places tag 3 at the tail.
REQ-039 SHALL verify that flush asserted together with alloc and free in RUN makes the next cycle INIT, with both requests ignored and count=7 after 7 cycles.
REQ-040 SHALL verify, with FREE_LIST_DOUBLE_FREE_CHECK_EN defined, that freeing tag 2 while it is still in the list sets double_free_err and leaves count unchanged.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// rtl/riscv_isa_pkg.sv - shared rename-side constants, physical tag type and free-list states
package riscv_isa;

   // Physical register file size; tag 0 is the hardwired x0 mapping
   localparam int O_COUNT = 128;
   localparam int PHYS_TW = $clog2(O_COUNT);

   typedef logic [PHYS_TW-1:0] phys_tag_t;

   // Free-list controller states: INIT rewrites the list, RUN serves rename/commit
   typedef enum logic {
      FL_INIT = 1'b0,
      FL_RUN  = 1'b1
   } fl_state_t;

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - physical register free list (circular FIFO); optional FREE_LIST_DOUBLE_FREE_CHECK_EN
module free_list #(
   parameter int  O_COUNT = riscv_isa::O_COUNT,
   localparam int TW      = $clog2(O_COUNT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   output logic          alloc_valid,
   input  logic          alloc_ready,
   output logic [TW-1:0] alloc_tag,
   input  logic          free_valid,
   input  logic [TW-1:0] free_tag,
   output logic          init_done,
   output logic [TW:0]   count
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   ,
   output logic          double_free_err
`endif
);
   import riscv_isa::*;

   // Tag 0 never lives in the list, so the FIFO holds O_COUNT-1 entries
   localparam logic [TW:0]   FULL     = (TW+1)'(O_COUNT - 1);
   localparam logic [TW-1:0] LAST_IDX = TW'(O_COUNT - 2);

   logic [TW-1:0] fifo [O_COUNT-1];
   fl_state_t     state_q, state_d;
   logic [TW-1:0] head_q, head_d;
   logic [TW-1:0] tail_q, tail_d;
   logic [TW:0]   count_q, count_d;
   logic          pop, push, free_req, dup;
   logic [TW-1:0] init_idx, init_tag;

   function automatic logic [TW-1:0] next_ptr(input logic [TW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   // During INIT the running count doubles as the write index
   assign init_idx  = count_q[TW-1:0];
   assign init_tag  = init_idx + 1'b1;
   assign alloc_tag = fifo[head_q];
   assign count     = count_q;
   assign init_done = (state_q == FL_RUN);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   logic [O_COUNT-1:0] in_list;
   assign dup = in_list[free_tag];
`else
   assign dup = 1'b0;
`endif

   // Next-state, pointer and count logic; flush overrides any pop or push
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      alloc_valid = (state_q == FL_RUN) && (count_q != '0);
      free_req    = (state_q == FL_RUN) && free_valid && (free_tag != '0);
      pop         = alloc_valid && alloc_ready;
      // A push into a full list only fits when a pop frees a slot the same cycle
      push        = free_req && !dup && ((count_q != FULL) || pop);
      if (flush) begin
         state_d = FL_INIT;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (state_q == FL_INIT) begin
         count_d = count_q + 1'b1;
         if (init_idx == LAST_IDX) begin
            state_d = FL_RUN;
         end
      end else begin
         if (pop) begin
            head_d = next_ptr(head_q);
         end
         if (push) begin
            tail_d = next_ptr(tail_q);
         end
         if (pop && !push) begin
            count_d = count_q - 1'b1;
         end else if (push && !pop) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // Control state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FL_INIT;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Tag storage is never reset; INIT rewrites every entry with its tag k+1
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (state_q == FL_INIT) begin
            fifo[init_idx] <= init_tag;
         end else if (push) begin
            fifo[tail_q] <= free_tag;
         end
      end
   end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   // Membership tracking and sticky double-free flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_list         <= '0;
         double_free_err <= 1'b0;
      end else if (flush) begin
         in_list         <= '0;
         double_free_err <= 1'b0;
      end else if (state_q == FL_INIT) begin
         in_list[init_tag] <= 1'b1;
      end else begin
         if (pop) begin
            in_list[alloc_tag] <= 1'b0;
         end
         if (push) begin
            in_list[free_tag] <= 1'b1;
         end
         if (free_req && dup) begin
            double_free_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - randomized and directed bench for free_list against a queue model
module tb_free_list;
   localparam int N  = 8;
   localparam int TW = 3;

   logic          clk         = 1'b0;
   logic          reset       = 1'b0;
   logic          flush       = 1'b0;
   logic          alloc_ready = 1'b0;
   logic          free_valid  = 1'b0;
   logic [TW-1:0] free_tag    = '0;
   logic          alloc_valid;
   logic [TW-1:0] alloc_tag;
   logic          init_done;
   logic [TW:0]   count;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   logic          double_free_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Behavioural model: list contents as a queue, INIT as a plain cycle counter
   int q[$];
   bit m_run  = 1'b0;
   int m_init = 0;
   bit m_err  = 1'b0;

   always #5 clk = ~clk;

   free_list #(.O_COUNT(N)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .alloc_valid(alloc_valid),
      .alloc_ready(alloc_ready),
      .alloc_tag(alloc_tag),
      .free_valid(free_valid),
      .free_tag(free_tag),
      .init_done(init_done),
      .count(count)
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      ,
      .double_free_err(double_free_err)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on every rising edge from the inputs applied that cycle
   always @(posedge clk) begin
      bit pop, push, dup;
      int ft;
      ft = int'(free_tag);
      if (!reset || flush) begin
         q.delete();
         m_run  = 1'b0;
         m_init = 0;
         m_err  = 1'b0;
      end else if (!m_run) begin
         m_init++;
         if (m_init == N - 1) begin
            m_run = 1'b1;
            for (int t = 1; t < N; t++) q.push_back(t);
         end
      end else begin
         pop = (q.size() != 0) && alloc_ready;
         dup = 1'b0;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
         foreach (q[i]) if (q[i] == ft) dup = 1'b1;
`endif
         push = free_valid && (ft != 0) && !dup && ((q.size() < N - 1) || pop);
         if (free_valid && (ft != 0) && dup) m_err = 1'b1;
         if (pop) void'(q.pop_front());
         if (push) q.push_back(ft);
      end
   end

   // Compare DUT outputs with the model on every falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_init_done", int'(init_done), int'(m_run));
         check("model_count", int'(count), m_run ? q.size() : m_init);
         check("model_alloc_valid", int'(alloc_valid), int'(m_run && (q.size() != 0)));
         if (m_run && (q.size() != 0)) check("model_alloc_tag", int'(alloc_tag), q[0]);
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
         check("model_double_free_err", int'(double_free_err), int'(m_err));
`endif
      end
   end

   task automatic drive(input bit f, input bit ar, input bit fv, input int ft);
      logic [31:0] t;
      t           = ft;
      flush       = f;
      alloc_ready = ar;
      free_valid  = fv;
      free_tag    = t[TW-1:0];
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      int exp4[4];
      int r;
      drive(0, 0, 0, 0);
      chk_en = 1'b1;
      repeat (3) tick();
      check("reset_count", int'(count), 0);
      check("reset_init_done", int'(init_done), 0);
      check("reset_alloc_valid", int'(alloc_valid), 0);

      // Reset release: INIT lasts exactly 7 cycles
      reset = 1'b1;
      repeat (6) tick();
      check("init_pending_at_6", int'(init_done), 0);
      check("init_count_at_6", int'(count), 6);
      tick();
      check("init_done_at_7", int'(init_done), 1);
      check("init_count_at_7", int'(count), 7);
      check("init_first_tag", int'(alloc_tag), 1);

      // Drain: tags 1..7 in order, then empty
      drive(0, 1, 0, 0);
      for (int k = 0; k < 7; k++) begin
         check("drain_tag", int'(alloc_tag), k + 1);
         tick();
      end
      check("drain_empty_valid", int'(alloc_valid), 0);
      check("drain_empty_count", int'(count), 0);
      tick();
      check("drain_8th_valid", int'(alloc_valid), 0);

      // No bypass: free of tag 5 while empty appears one cycle later
      drive(0, 0, 1, 5);
      check("nobypass_same_cycle", int'(alloc_valid), 0);
      tick();
      drive(0, 0, 0, 0);
      check("nobypass_next_valid", int'(alloc_valid), 1);
      check("nobypass_next_tag", int'(alloc_tag), 5);

      // Build count 4 then simultaneous alloc and free of tag 3
      drive(0, 0, 1, 6); tick();
      drive(0, 0, 1, 7); tick();
      drive(0, 0, 1, 1); tick();
      drive(0, 0, 0, 0);
      check("build_count4", int'(count), 4);
      drive(0, 1, 1, 3);
      check("simul_head_tag", int'(alloc_tag), 5);
      tick();
      drive(0, 0, 0, 0);
      check("simul_count_kept", int'(count), 4);
      exp4 = '{6, 7, 1, 3};
      drive(0, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         check("simul_order", int'(alloc_tag), exp4[k]);
         tick();
      end
      drive(0, 0, 0, 0);
      check("simul_drained", int'(count), 0);

      // Flush together with alloc and free
      drive(0, 0, 1, 2); tick();
      check("preflush_count", int'(count), 1);
      drive(1, 1, 1, 4); tick();
      drive(0, 0, 0, 0);
      check("flush_init", int'(init_done), 0);
      check("flush_count0", int'(count), 0);
      repeat (6) tick();
      check("flush_init_pending", int'(init_done), 0);
      tick();
      check("flush_rerun", int'(init_done), 1);
      check("flush_count7", int'(count), 7);
      check("flush_first_tag", int'(alloc_tag), 1);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      // Double free of tag 2 while still listed
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 1, 2); tick();
      drive(0, 0, 0, 0);
      check("dfree_err", int'(double_free_err), 1);
      check("dfree_count", int'(count), 6);
      drive(0, 0, 1, 1); tick();
      drive(0, 0, 0, 0);
      check("dfree_refill", int'(count), 7);
      check("dfree_sticky", int'(double_free_err), 1);
`endif

      // Push into a full list without pop is dropped
      drive(0, 0, 1, 3); tick();
      drive(0, 0, 0, 0);
      check("saturate_count", int'(count), 7);
      // Free of tag 0 is ignored
      drive(0, 1, 1, 0); tick();
      drive(0, 0, 0, 0);
      check("tag0_ignored", int'(count), 6);

      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0);
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      check("flush_clears_err", int'(double_free_err), 0);
`endif
      repeat (7) tick();

      // Randomized traffic with occasional flush and reset
      for (int c = 0; c < 3000; c++) begin
         r           = $urandom_range(0, 199);
         reset       = (r != 0);
         flush       = ($urandom_range(0, 63) == 0);
         alloc_ready = $urandom_range(0, 1);
         free_valid  = ($urandom_range(0, 2) != 0);
         free_tag    = TW'($urandom_range(0, N - 1));
         tick();
      end
      reset = 1'b1;
      drive(0, 0, 0, 0);
      tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
